// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scanner.
// Contents: FSM state enum, 16-entry key map indexed {row,col}, idle column pattern, key decode helper.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam logic [3:0] COLS_IDLE = 4'hF;

    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the digit/load strobe pair.
// Signals: cols (active-low columns), rows (active-low one-hot rows), digit (hex key code), load (1-cycle strobe).
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] digit;
    logic       load;

    modport master (input cols, output rows, output digit, output load);
    modport slave  (output cols, input rows, input digit, input load);
endinterface

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: 2-flop synchronizer bringing the asynchronous keypad columns into the clk domain.
// Ports: clk, reset (async, active high), cols (raw columns), cs (synchronized columns, reset to idle).
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] cs
);
    logic [3:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= COLS_IDLE;
            cs   <= COLS_IDLE;
        end else begin
            meta <= cols;
            cs   <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces press and release, emits key code with a one-cycle load.
// Ports: clk, reset (async, active high), kp (master modport: cols in, rows/digit/load out).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master kp
);
    localparam int CW = $clog2(SCAN_DIV > DEBOUNCE_CYCLES ? SCAN_DIV : DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] dwell, dwell_n, deb, deb_n;
    logic [1:0]    row, row_n, col, col_n, col_hit;
    logic [3:0]    cs, pat, pat_n, digit_q, digit_n;
    logic          load_q, load_n, single;

    keypad_col_sync u_sync (.clk(clk), .reset(reset), .cols(kp.cols), .cs(cs));

    assign single   = $countones(~cs) == 1;
    assign col_hit  = !cs[0] ? 2'd0 : !cs[1] ? 2'd1 : !cs[2] ? 2'd2 : 2'd3;
    assign kp.rows  = ~(4'b0001 << row);
    assign kp.digit = digit_q;
    assign kp.load  = load_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            dwell   <= '0;
            deb     <= '0;
            row     <= 2'd0;
            col     <= 2'd0;
            pat     <= COLS_IDLE;
            digit_q <= 4'h0;
            load_q  <= 1'b0;
        end else begin
            state   <= state_n;
            dwell   <= dwell_n;
            deb     <= deb_n;
            row     <= row_n;
            col     <= col_n;
            pat     <= pat_n;
            digit_q <= digit_n;
            load_q  <= load_n;
        end
    end

    // The row stays driven through DEBOUNCE and HELD so the latched pattern remains observable.
    always_comb begin
        state_n = state;
        dwell_n = dwell;
        deb_n   = deb;
        row_n   = row;
        col_n   = col;
        pat_n   = pat;
        digit_n = digit_q;
        load_n  = 1'b0;
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    if (single) begin
                        state_n = DEBOUNCE;
                        col_n   = col_hit;
                        pat_n   = cs;
                        deb_n   = '0;
                    end else begin
                        row_n = row + 2'd1;
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (cs != pat) begin
                    state_n = SCAN;
                    dwell_n = '0;
                end else if (deb == DEB_LAST) begin
                    state_n = HELD;
                    digit_n = key_code(row, col);
                    load_n  = 1'b1;
                    deb_n   = '0;
                end else begin
                    deb_n = deb + 1'b1;
                end
            end
            HELD: begin
                if (cs != COLS_IDLE) begin
                    deb_n = '0;
                end else if (deb == DEB_LAST) begin
                    state_n = SCAN;
                    row_n   = row + 2'd1;
                    dwell_n = '0;
                    deb_n   = '0;
                end else begin
                    deb_n = deb + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and produces the `digit`/`load` pair consumed by the motor/VGA top level. This block is the source side of that interface.
- Drives one active-low row at a time and samples the synchronized active-low columns.
- Debounces press and release, then emits the hex key code with a one-cycle `load` strobe per press.

Parameters:
- SCAN_DIV, 50000, clock cycles each row is driven before sampling/advancing (>=2).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or a release (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cols  input  4  keypad columns, active low, externally pulled up, asynchronous to clk
- rows  output  4  keypad rows, active-low one-hot drive
- digit  output  4  hex code of last accepted key
- load  output  1  one-cycle pulse when `digit` is updated

Behaviour:
- Column synchronization:
  - `cols` passes through a 2-flop synchronizer; all decisions use the synchronized value `cs`.
  - Synchronizer flops reset to 4'hF.
- Reset values (asynchronous):
  - rows=4'b1110 (row0), digit=4'h0, load=0, state=SCAN.
  - Dwell and debounce counters = 0.
- Key map, row r / col c (col0 = bit0):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Decoding is a pure function of the latched row index and column index.
- State SCAN:
  - The dwell counter counts 0..SCAN_DIV-1. Sampling happens only at terminal count, after the row has settled.
  - At terminal count, if exactly one bit of `cs` is 0: latch row/col indices and the `cs` pattern, clear the debounce counter, keep `rows` unchanged, go to DEBOUNCE.
  - Otherwise (all high, or two or more low): rotate the active row to the next one (row3 wraps to row0) and restart the dwell.
- State DEBOUNCE (row held):
  - Each cycle `cs` equals the latched pattern: increment the counter.
  - If `cs` differs: return to SCAN on the same row with the dwell restarted. No `load` is emitted.
  - When the counter reaches DEBOUNCE_CYCLES: on that same clock edge set digit=decoded key and load=1, clear the counter, go to HELD.
- State HELD (row held):
  - load=0 from the next cycle on, so `load` is exactly 1 cycle wide.
  - Each cycle cs==4'hF: increment the counter. Any 0 bit in `cs`: clear the counter.
  - When the counter reaches DEBOUNCE_CYCLES: go to SCAN, advance to the next row, restart the dwell.
  - A second key pressed while the first is held produces no output.
- `digit` holds its value until the next accepted press. Repeated presses of the same key each pulse `load`.
- Latency, press to `load`: up to 4*SCAN_DIV (find the row) + 2 (synchronizer) + DEBOUNCE_CYCLES cycles. Exactly DEBOUNCE_CYCLES cycles after the matching sample.
- Reset mid-operation: immediately returns to the reset values. A press that was already held is re-detected as a new press once reset is released.
- Counter width: $clog2 of the larger of SCAN_DIV and DEBOUNCE_CYCLES, plus 1. No wrap occurs, because each counter is cleared at its terminal value.

Decomposition:
- Package keypad_pkg holds:
  - enum state_t {SCAN, DEBOUNCE, HELD};
  - the 16-entry key map constant, indexed {row,col};
  - the idle column constant COLS_IDLE=4'hF.
- One sub-module, keypad_col_sync: the 2-flop 4-bit synchronizer with async reset to 4'hF.
- The FSM, counters and decode live in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset, no keys: `rows` cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 clk; load stays 0; digit=0.
- Press r2/c1 (model pulls col1 low only while row2 is low), hold 40 cycles, release:
  - one `load` pulse with digit=4'h8, arriving 8 cycles after the matching sample;
  - rows stays 1011 until 8 idle cycles after release, then 0111.
- Bounce: col0 on r0 toggles every 3 cycles for 30 cycles, then stays low:
  - no `load` during the bounce;
  - exactly one `load`, with digit=4'h1, after the signal stabilizes.
- Two keys r1/c0 and r1/c3 pressed together: no `load`, and scanning continues. Then release c3: `load` with digit=4'h4.
- Hold r3/c2 (digit F), press r0/c0 while F is held, release both: a single `load` (digit=F); the r0 key is ignored.
- Assert reset while in HELD:
  - rows=1110, load=0 immediately, digit=0;
  - the still-held r3/c1 key is re-accepted after release of reset, giving `load` with digit=4'h0.
